// File: rtl/register_file.sv
// register_file: 32x32 integer register file, two registered read ports with write-first bypass, post-reset clear sequencer
module register_file (
  input  logic        clock,
  input  logic        reset,
  input  logic        rden1,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic        rden2,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2,
  input  logic        wren,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  output logic        ready
);
  typedef enum logic {INIT, RUN} state_t;
  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] mem [32];
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_din, rd1, rd2;
  always_comb begin
    mem_we   = !reset && (state == INIT || (wren && waddr != 5'd0));
    mem_addr = state == INIT ? cnt : waddr;
    mem_din  = state == INIT ? '0 : wdata;
    rd1      = raddr1 == 5'd0 ? '0 : (wren && waddr == raddr1) ? wdata : mem[raddr1];
    rd2      = raddr2 == 5'd0 ? '0 : (wren && waddr == raddr2) ? wdata : mem[raddr2];
  end
  always_ff @(posedge clock)
    if (mem_we) mem[mem_addr] <= mem_din;
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= INIT;
      cnt    <= '0;
      rdata1 <= '0;
      rdata2 <= '0;
      ready  <= 1'b0;
    end else if (state == INIT) begin
      cnt <= cnt + 5'd1;
      if (cnt == 5'd31) begin
        state <= RUN;
        ready <= 1'b1;
      end
    end else begin
      if (rden1) rdata1 <= rd1;
      if (rden2) rdata2 <= rd2;
    end
  end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: random and directed traffic against a write-then-read array model of the register file
module tb_register_file;
  logic        clock = 0, reset = 1;
  logic        rden1 = 0, rden2 = 0, wren = 0;
  logic [4:0]  raddr1 = 0, raddr2 = 0, waddr = 0;
  logic [31:0] wdata = 0;
  logic [31:0] rdata1, rdata2;
  logic        ready;
  int vectors = 0, miscompares = 0;

  register_file dut (
    .clock(clock), .reset(reset),
    .rden1(rden1), .raddr1(raddr1), .rdata1(rdata1),
    .rden2(rden2), .raddr2(raddr2), .rdata2(rdata2),
    .wren(wren), .waddr(waddr), .wdata(wdata), .ready(ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // model: clear takes 32 non-reset edges; in run, apply the write then read, so bypass falls out naturally
  logic [31:0] m [32];
  logic [31:0] e1, e2;
  logic        er;
  bit          valid = 0;
  int          left = 0;
  always @(posedge clock) begin
    if (reset) begin
      valid = 1; left = 32; e1 = 0; e2 = 0; er = 0;
    end else if (valid) begin
      if (left > 0) begin
        left--;
        if (left == 0) begin
          foreach (m[i]) m[i] = 0;
          er = 1;
        end
      end else begin
        if (wren && waddr != 0) m[waddr] = wdata;
        if (rden1) e1 = m[raddr1];
        if (rden2) e2 = m[raddr2];
      end
    end
    #1;
    if (valid) begin
      check("model_ready", {31'd0, ready}, {31'd0, er});
      check("model_rdata1", rdata1, e1);
      check("model_rdata2", rdata2, e2);
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  initial begin
    repeat (3) tick();
    reset = 0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      check($sformatf("ready_edge%0d", i), {31'd0, ready}, (i == 32) ? 32'd1 : 32'd0);
    end
    rden1 = 1; rden2 = 1;
    for (int a = 0; a < 32; a++) begin
      raddr1 = a[4:0]; raddr2 = 5'(31 - a);
      tick();
      check("cleared_p1", rdata1, 32'h0);
      check("cleared_p2", rdata2, 32'h0);
    end
    rden1 = 0; rden2 = 0;
    wren = 1; waddr = 5; wdata = 32'hDEADBEEF;
    tick();
    wren = 0; rden1 = 1; raddr1 = 5; rden2 = 1; raddr2 = 5;
    tick();
    check("x5_p1", rdata1, 32'hDEADBEEF);
    check("x5_p2", rdata2, 32'hDEADBEEF);
    wren = 1; waddr = 0; wdata = 32'h12345678; raddr1 = 0; rden2 = 0;
    tick();
    check("x0_bypass", rdata1, 32'h0);
    wren = 0;
    tick();
    check("x0_after", rdata1, 32'h0);
    rden1 = 0;
    wren = 1; waddr = 7; wdata = 32'h1;
    tick();
    wdata = 32'hA5A5A5A5; rden1 = 1; raddr1 = 7;
    tick();
    check("x7_bypass", rdata1, 32'hA5A5A5A5);
    wren = 0; rden1 = 0; rden2 = 1; raddr2 = 7;
    tick();
    check("x7_p2", rdata2, 32'hA5A5A5A5);
    rden2 = 0; rden1 = 1; raddr1 = 5;
    tick();
    check("hold_pre", rdata1, 32'hDEADBEEF);
    rden1 = 0; raddr1 = 9; wren = 1; waddr = 5; wdata = 32'h0;
    tick();
    check("hold_1", rdata1, 32'hDEADBEEF);
    wren = 0; raddr1 = 3;
    tick();
    check("hold_2", rdata1, 32'hDEADBEEF);
    rden1 = 1; raddr1 = 5;
    tick();
    check("hold_release", rdata1, 32'h0);
    rden1 = 0;
    wren = 1; waddr = 3; wdata = 32'hCAFEF00D;
    tick();
    wren = 0; rden2 = 1; raddr2 = 3;
    tick();
    check("x3_written", rdata2, 32'hCAFEF00D);
    rden2 = 0;
    reset = 1;
    tick();
    check("run_reset_ready", {31'd0, ready}, 32'd0);
    check("run_reset_rd2", rdata2, 32'h0);
    reset = 0; wren = 1; waddr = 9; wdata = 32'hFFFFFFFF;
    repeat (10) tick();
    check("init_ready", {31'd0, ready}, 32'd0);
    reset = 1;
    tick();
    check("init_reset_ready", {31'd0, ready}, 32'd0);
    reset = 0; rden1 = 1; raddr1 = 3;
    for (int i = 1; i <= 32; i++) begin
      tick();
      check($sformatf("reclear_ready%0d", i), {31'd0, ready}, (i == 32) ? 32'd1 : 32'd0);
      check("reclear_rd1", rdata1, 32'h0);
    end
    wren = 0; rden2 = 1; raddr2 = 9;
    tick();
    check("x3_cleared", rdata1, 32'h0);
    check("x9_ignored", rdata2, 32'h0);
    for (int c = 0; c < 10000; c++) begin
      rden1 = 1'($urandom); rden2 = 1'($urandom); wren = 1'($urandom);
      raddr1 = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      raddr2 = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      waddr  = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      if ($urandom_range(0, 3) == 0) waddr = raddr1;
      wdata = $urandom;
      tick();
    end
    wren = 0; rden1 = 0; rden2 = 0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/register_file.md
# register_file

Integer register file for the in-order core: 32 × 32-bit entries, two synchronous read ports feeding the decode-to-execute operand path (register data consumed by the operand forwarding stage), one write port driven by writeback. On FPGA it maps to block RAM, so contents are not resettable in place. A post-reset clear sequencer zeroes all entries and holds `ready` low until done.

## Interface
- No parameters: data width fixed at 32, depth fixed at 32 entries (5-bit addresses).
- `clock`  in  1  sole clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `rden1`  in  1  read enable, port 1
- `raddr1`  in  5  read address, port 1
- `rdata1`  out  32  registered read data, port 1
- `rden2`  in  1  read enable, port 2
- `raddr2`  in  5  read address, port 2
- `rdata2`  out  32  registered read data, port 2
- `wren`  in  1  write enable
- `waddr`  in  5  write address
- `wdata`  in  32  write data
- `ready`  out  1  high once the clear sequence has completed; pipeline must not issue until high

## Operation
- State machine: INIT, RUN.
- Reset (edge with `reset`=1): state←INIT, clear counter←0, `rdata1`=`rdata2`←0, `ready`←0. Takes priority over everything, including mid-clear or mid-run; re-entering INIT restarts the clear from entry 0.
- INIT (`reset`=0): each edge writes 0 to entry[counter] and increments the counter (5-bit). On the edge clearing entry 31: state←RUN, `ready`←1. External `wren` ignored. `rden1`/`rden2` ignored; `rdata1`/`rdata2` stay 0.
- RUN, write: `wren`=1 and `waddr`≠0 → entry[waddr]←wdata. Writes to address 0 are discarded; entry 0 always reads 0.
- RUN, read port n: `rdenN`=1 → `rdataN`← 0 if `raddrN`=0; else `wdata` if `wren`=1 and `waddr`=`raddrN` (write-first bypass); else entry[raddrN]. `rdenN`=0 → `rdataN` holds its previous value.
- Both ports may read the same address in the same cycle; both return identical data.
- `ready` stays 1 in RUN until the next reset.

## Timing
- Read latency 1 cycle: address/enable sampled at edge k, data valid after edge k and stable until the next enabled read.
- Write latency 1 cycle: data written at edge k is returned by a read sampled at edge k (bypass) or any later edge.
- Clear sequence: exactly 32 edges after the first edge with `reset`=0. `ready` rises on the 32nd edge.
- Reset values: `rdata1`=0, `rdata2`=0, `ready`=0.
- No combinational path from any input to any output.

## Test plan
- Reset for 3 cycles, release → `ready` low for 31 edges, high after the 32nd. Then read all 32 addresses on both ports → every read returns 0x00000000.
- After `ready`: write 0xDEADBEEF to x5, next cycle read x5 on port 1 and x5 on port 2 → both return 0xDEADBEEF. Write 0x12345678 to x0, read x0 → returns 0.
- Same-cycle write x7←0xA5A5A5A5 with `rden1`=1, `raddr1`=7, prior x7=0x1 → `rdata1`=0xA5A5A5A5 one cycle later. `rdata2` reading x7 in the following cycle also returns 0xA5A5A5A5.
- Read x5 (0xDEADBEEF), then hold `rden1`=0 while changing `raddr1` and writing x5←0x0 → `rdata1` stays 0xDEADBEEF until `rden1` reasserted.
- Write x3←0xCAFEF00D. Assert reset for 1 cycle at clear-counter 10 of a second INIT and also mid-RUN → `ready` drops, `rdata` outputs 0. After the full 32-cycle clear, x3 reads 0. Writes issued during INIT (x9←0xFFFFFFFF) leave x9=0.
- Random RUN traffic (10k cycles, both ports, bypass collisions) checked against a reference model → zero mismatches.
